// File: rtl/uart_rx_os_if.sv
// Interface bundling the serial input, baud tick and received-word outputs
// of the oversampled UART receiver. The receiver takes the master modport,
// the line/tick driver and word consumer take the slave modport.
interface uart_rx_os_if #(
  parameter int DBIT = 8
);
  logic            i_s_tick;
  logic            i_rx;
  logic [DBIT-1:0] o_dout;
  logic            o_rx_done_tick;
  logic            o_frame_err;
  logic            o_parity_err;

  modport master (
    input  i_s_tick,
    input  i_rx,
    output o_dout,
    output o_rx_done_tick,
    output o_frame_err,
    output o_parity_err
  );

  modport slave (
    output i_s_tick,
    output i_rx,
    input  o_dout,
    input  o_rx_done_tick,
    input  o_frame_err,
    input  o_parity_err
  );
endinterface

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampled UART receiver, LSB first.
// Synchronises the serial line, frames start/data/[parity]/stop bits and
// presents each received word with a one-cycle done pulse plus error flags.
// Optional feature macro: UART_RX_PARITY_EN (one even-parity bit after data).
module uart_rx_os #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  uart_rx_os_if.master   bus
);

  localparam int NW = $clog2(DBIT);

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = 1'b0;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state, state_n;
  logic [4:0]      s, s_n;
  logic [NW-1:0]   n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic            rx_meta, rx_s, rx_prev;
  logic            done_set;
`ifdef UART_RX_PARITY_EN
  logic            p_err, p_err_n;
`endif

  // Two-flop synchroniser plus one history flop so idle only reacts to a real 1->0 edge.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= bus.i_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // FSM state and datapath registers; counters are cleared on every state change.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
`ifdef UART_RX_PARITY_EN
      p_err <= 1'b0;
`endif
    end else begin
      state <= state_n;
      s     <= s_n;
      n     <= n_n;
      b     <= b_n;
`ifdef UART_RX_PARITY_EN
      p_err <= p_err_n;
`endif
    end
  end

  // Next-state logic: a tick in the cycle of a state change belongs to the current state only.
  always_comb begin
    state_n  = state;
    s_n      = s;
    n_n      = n;
    b_n      = b;
    done_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    p_err_n  = p_err;
`endif
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (bus.i_s_tick) begin
          if (s == 5'd7) begin
            s_n = '0;
            if (!rx_s) begin
              state_n = DATA;
              n_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s + 5'd1;
          end
        end
      end
      DATA: begin
        if (bus.i_s_tick) begin
          if (s == 5'd15) begin
            s_n = '0;
            b_n = {rx_s, b[DBIT-1:1]};
            if (n == NW'(DBIT-1)) begin
              n_n = '0;
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              n_n = n + NW'(1);
            end
          end else begin
            s_n = s + 5'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bus.i_s_tick) begin
          if (s == 5'd15) begin
            p_err_n = rx_s ^ (^b) ^ PAR_ODD;
            state_n = STOP;
            s_n     = '0;
          end else begin
            s_n = s + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (bus.i_s_tick) begin
          if (s == 5'(SB_TICK-1)) begin
            state_n  = IDLE;
            s_n      = '0;
            done_set = 1'b1;
          end else begin
            s_n = s + 5'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        s_n     = '0;
        n_n     = '0;
      end
    endcase
  end

  // Output registers: word and error flags load together with the done pulse and hold until the next frame.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      bus.o_dout         <= '0;
      bus.o_rx_done_tick <= 1'b0;
      bus.o_frame_err    <= 1'b0;
      bus.o_parity_err   <= 1'b0;
    end else begin
      bus.o_rx_done_tick <= done_set;
      if (done_set) begin
        bus.o_dout      <= b;
        bus.o_frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
        bus.o_parity_err <= p_err;
`else
        bus.o_parity_err <= 1'b0;
`endif
      end
    end
  end

endmodule
